// File: rtl/mul_seq_16bit_if.sv
// rtl/mul_seq_16bit_if.sv - start/done request bundle for the sequential 16x16 multiplier
//
// Purpose: carries one multiply request (operands, signedness, start) toward the
// multiplier and its status/result (busy, done, product) back to the requester.
// Signals:
//   start      requester -> multiplier  request, accepted only in IDLE or DONE
//   is_signed  requester -> multiplier  1 = two's complement operands
//   x          requester -> multiplier  16-bit multiplicand
//   y          requester -> multiplier  16-bit multiplier
//   busy       multiplier -> requester  high while stepping
//   done       multiplier -> requester  one-cycle pulse, product valid
//   product    multiplier -> requester  32-bit registered result

interface mul_seq_16bit_if;
    logic        start;
    logic        is_signed;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start,
        output is_signed,
        output x,
        output y,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  is_signed,
        input  x,
        input  y,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/mul_seq_16bit.sv
// rtl/mul_seq_16bit.sv - sequential shift-add 16x16 signed/unsigned multiplier
//
// Purpose: computes a 32-bit product one partial-product row per clock over
// 16 clocks, with a start/busy/done handshake. Signed operands use two's
// complement; the final row is subtracted because the multiplier MSB carries
// negative weight.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mul_seq_16bit_if.slave (start, is_signed, x, y in; busy, done, product out)

module mul_seq_16bit (
    input  logic               clk,
    input  logic               rst_n,
    mul_seq_16bit_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [16:0] a_q;        // running high partial product (one guard bit)
    logic [15:0] q_q;        // remaining multiplier bits, low product bits shift in
    logic [15:0] m_q;        // latched multiplicand
    logic        s_q;        // latched signedness
    logic [3:0]  k_q;        // step index
    logic        busy_q;
    logic        done_q;
    logic [31:0] product_q;

    // One recurrence step in 18-bit arithmetic.
    logic [17:0] xe_d;
    logic [17:0] ae_d;
    logic [17:0] addend_d;
    logic [17:0] t_d;

    always_comb begin
        xe_d     = s_q ? {{2{m_q[15]}}, m_q} : {2'b00, m_q};
        ae_d     = s_q ? {a_q[16], a_q}      : {1'b0, a_q};
        addend_d = q_q[0] ? xe_d : 18'd0;
        // Last row of a signed multiplier has weight -2^15, so subtract it.
        if (s_q && (k_q == 4'd15)) begin
            t_d = ae_d - addend_d;
        end else begin
            t_d = ae_d + addend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= 17'd0;
            q_q       <= 16'd0;
            m_q       <= 16'd0;
            s_q       <= 1'b0;
            k_q       <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 32'd0;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE, giving
                // back-to-back operation without a gap cycle.
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q     <= bus.x;
                        q_q     <= bus.y;
                        s_q     <= bus.is_signed;
                        a_q     <= 17'd0;
                        k_q     <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q <= t_d[17:1];
                    q_q <= {t_d[0], q_q[15:1]};
                    k_q <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        // Product captured from the same step result so it is
                        // valid in the DONE cycle.
                        product_q <= {t_d[16:1], t_d[0], q_q[15:1]};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq_16bit.sv
// tb/tb_mul_seq_16bit.sv - self-checking bench for mul_seq_16bit

module tb_mul_seq_16bit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mul_seq_16bit_if bus_if ();

    mul_seq_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as the requester sees them.
    function automatic logic [31:0] ref_mul(input bit s, input logic [15:0] a, input logic [15:0] b);
        int     sa;
        int     sb;
        longint p;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = longint'(sa) * longint'(sb);
        end else begin
            p  = longint'({16'd0, a}) * longint'({16'd0, b});
        end
        return p[31:0];
    endfunction

    // Called just after a negedge; leaves the bench 1 time unit after the accepting edge.
    task automatic start_op(input bit s, input logic [15:0] a, input logic [15:0] b);
        bus_if.start     = 1'b1;
        bus_if.is_signed = s;
        bus_if.x         = a;
        bus_if.y         = b;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    // Waits for done, checking latency, busy span and product; returns at the done-cycle negedge.
    task automatic wait_done(input string tag, input logic [31:0] exp, input bit noisy);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!bus_if.done && cyc < 40) begin
            busy_cnt += int'(bus_if.busy);
            if (noisy) begin
                bus_if.start     = 1'($urandom);
                bus_if.is_signed = 1'($urandom);
                bus_if.x         = 16'($urandom);
                bus_if.y         = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus_if.start = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'd16);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
        check_eq({tag, "_busy_at_done"}, {31'd0, bus_if.busy}, 32'd0);
        check_eq({tag, "_product"}, bus_if.product, exp);
    endtask

    // Idle cycles after completion: no further done, product held.
    task automatic idle_hold(input string tag, input int n, input logic [31:0] exp);
        int extra_done;
        int prod_bad;
        extra_done = 0;
        prod_bad   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            extra_done += int'(bus_if.done);
            if (bus_if.product !== exp) prod_bad++;
        end
        check_eq({tag, "_no_extra_done"}, 32'(extra_done), 32'd0);
        check_eq({tag, "_product_held"}, 32'(prod_bad), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rs;
        int          stray_done;

        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.is_signed = 1'b0;
        bus_if.x         = 16'h0000;
        bus_if.y         = 16'h0000;

        repeat (3) @(negedge clk);
        check_eq("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check_eq("reset_done", {31'd0, bus_if.done}, 32'd0);
        check_eq("reset_product", bus_if.product, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(1'b1, 16'h0003, 16'h0005);
        wait_done("s3x5", 32'h0000_000F, 1'b0);
        idle_hold("s3x5", 3, 32'h0000_000F);

        start_op(1'b1, 16'hFFFF, 16'hFFFF);
        wait_done("sm1xm1", 32'h0000_0001, 1'b0);
        idle_hold("sm1xm1", 1, 32'h0000_0001);

        start_op(1'b1, 16'h8000, 16'h8000);
        wait_done("smin_sq", 32'h4000_0000, 1'b0);
        idle_hold("smin_sq", 1, 32'h4000_0000);

        start_op(1'b1, 16'h0007, 16'hFFFD);
        wait_done("s7xm3", 32'hFFFF_FFEB, 1'b0);
        idle_hold("s7xm3", 1, 32'hFFFF_FFEB);

        start_op(1'b1, 16'h8000, 16'h7FFF);
        wait_done("sminxmax", 32'hC000_8000, 1'b0);
        idle_hold("sminxmax", 1, 32'hC000_8000);

        start_op(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done("u_max_sq", 32'hFFFE_0001, 1'b0);
        idle_hold("u_max_sq", 1, 32'hFFFE_0001);

        start_op(1'b1, 16'h0ABC, 16'h0123);
        wait_done("noisy", 32'h000C_33B4, 1'b1);
        idle_hold("noisy", 4, 32'h000C_33B4);

        // Back-to-back: second request presented in the DONE cycle.
        start_op(1'b1, 16'h1234, 16'h0010);
        wait_done("b2b_first", 32'h0001_2340, 1'b0);
        start_op(1'b1, 16'h0002, 16'h0003);
        wait_done("b2b_second", 32'h0000_0006, 1'b0);
        idle_hold("b2b_second", 3, 32'h0000_0006);

        // Reset asserted so that the edge performing step k=8 sees it.
        start_op(1'b0, 16'h00FF, 16'h0101);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
        check_eq("midrst_done", {31'd0, bus_if.done}, 32'd0);
        check_eq("midrst_product", bus_if.product, 32'd0);
        rst_n = 1'b1;
        stray_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stray_done += int'(bus_if.done);
        end
        check_eq("midrst_no_done", 32'(stray_done), 32'd0);
        start_op(1'b0, 16'h00FF, 16'h0101);
        wait_done("after_rst", 32'h0000_FFFF, 1'b0);
        idle_hold("after_rst", 1, 32'h0000_FFFF);

        // Reset coincident with start: reset wins and the request is not queued.
        rst_n        = 1'b0;
        bus_if.start = 1'b1;
        @(negedge clk);
        check_eq("rst_start_busy", {31'd0, bus_if.busy}, 32'd0);
        rst_n        = 1'b1;
        bus_if.start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_busy_after", {31'd0, bus_if.busy}, 32'd0);

        // Randomized operations, some chained back-to-back, some with noisy inputs.
        for (int n = 0; n < 30; n++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ra = 16'h8000;
                1: rb = 16'hFFFF;
                default: ;
            endcase
            start_op(rs, ra, rb);
            wait_done($sformatf("rnd%0d", n), ref_mul(rs, ra, rb), 1'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                idle_hold($sformatf("rnd%0d", n), int'($urandom_range(1, 3)), ref_mul(rs, ra, rb));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
